alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 139 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Issues one ALU command at a time: latches operands, waits SETTLE cycles, then captures the
// ALU result and status. Also checks the compare flags and counts mismatches.
module alu_cmd_issuer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [1:0] cmd_op,

    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_y,
    input  logic       alu_parity,
    input  logic       alu_overflow,
    input  logic       alu_greater,
    input  logic       alu_is_eq,
    input  logic       alu_less,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic [4:0] rsp_flags,
    output logic       rsp_err,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StResp
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [1:0] op_q, op_d;
    logic [7:0] y_q, y_d;
    logic [4:0] flags_q, flags_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [2:0] cmp_exp;
    logic [2:0] cmp_got;
    logic       mismatch;

    // Reference compare is taken from the held operands, not the live command inputs.
    assign cmp_exp  = {a_q > b_q, a_q == b_q, a_q < b_q};
    assign cmp_got  = {alu_greater, alu_is_eq, alu_less};
    assign mismatch = (cmp_got != cmp_exp);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        y_d       = y_q;
        flags_d   = flags_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    cnt_d   = CntLoad;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == 4'd0) begin
                    y_d     = alu_y;
                    flags_d = {alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less};
                    err_d   = mismatch;
                    if (mismatch && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            op_q      <= 2'b00;
            y_q       <= 8'h00;
            flags_q   <= 5'b00000;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            y_q       <= y_d;
            flags_q   <= flags_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign rsp_y     = y_q;
    assign rsp_flags = flags_q;
    assign rsp_err   = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a SETTLE=2 instance driven by table, random and corner sequences,
// and a SETTLE=4 instance for the reset-during-drive case.
module tb_alu_cmd_issuer;

    localparam int unsigned Settle2 = 2;
    localparam int unsigned Settle4 = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cmd_a, cmd_b;
    logic [1:0] cmd_op;

    // SETTLE=2 instance
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [7:0] alu_a, alu_b, alu_y, rsp_y, err_cnt;
    logic [1:0] alu_op;
    logic       alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less;
    logic [4:0] rsp_flags;

    // SETTLE=4 instance
    logic       cmd_valid4, cmd_ready4, rsp_valid4, rsp_ready4, rsp_err4;
    logic [7:0] alu_a4, alu_b4, alu_y4, rsp_y4, err_cnt4;
    logic [1:0] alu_op4;
    logic       alu_parity4, alu_overflow4, alu_greater4, alu_is_eq4, alu_less4;
    logic [4:0] rsp_flags4;

    logic [1:0] flag_mode;
    logic [7:0] y_noise;

    int n_vec = 0;
    int n_err = 0;
    int ref_cnt = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.SETTLE(Settle2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .alu_parity(alu_parity), .alu_overflow(alu_overflow), .alu_greater(alu_greater),
        .alu_is_eq(alu_is_eq), .alu_less(alu_less),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .err_cnt(err_cnt)
    );

    alu_cmd_issuer #(.SETTLE(Settle4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_y(alu_y4),
        .alu_parity(alu_parity4), .alu_overflow(alu_overflow4), .alu_greater(alu_greater4),
        .alu_is_eq(alu_is_eq4), .alu_less(alu_less4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_y(rsp_y4),
        .rsp_flags(rsp_flags4), .rsp_err(rsp_err4), .err_cnt(err_cnt4)
    );

    function automatic logic [7:0] calc(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic ovf(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int s;
        s = int'(a) + int'(b);
        if (op == 2'd0) return s > 255;
        if (op == 2'd1) return a < b;
        return 1'b0;
    endfunction

    // mode 0 = honest ALU, 1 = greater only, 2 = zero-hot, 3 = all set
    function automatic logic [2:0] cmp_pat(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] mode);
        case (mode)
            2'd0:    return {a > b, a == b, a < b};
            2'd1:    return 3'b100;
            2'd2:    return 3'b000;
            default: return 3'b111;
        endcase
    endfunction

    // Environment ALU models
    always_comb begin
        alu_y        = calc(alu_a, alu_b, alu_op) ^ y_noise;
        alu_parity   = ^calc(alu_a, alu_b, alu_op);
        alu_overflow = ovf(alu_a, alu_b, alu_op);
        {alu_greater, alu_is_eq, alu_less} = cmp_pat(alu_a, alu_b, flag_mode);
    end

    always_comb begin
        alu_y4        = calc(alu_a4, alu_b4, alu_op4);
        alu_parity4   = ^calc(alu_a4, alu_b4, alu_op4);
        alu_overflow4 = ovf(alu_a4, alu_b4, alu_op4);
        {alu_greater4, alu_is_eq4, alu_less4} = cmp_pat(alu_a4, alu_b4, 2'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic [1:0] mode, input int hold,
                          input logic [7:0] ey, input logic eerr);
        logic [4:0] eflags;
        int n;
        eflags = {^ey, ovf(a, b, op), cmp_pat(a, b, mode)};
        if (eerr && ref_cnt < 255) ref_cnt++;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        flag_mode = mode;
        y_noise   = 8'h00;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_op    = 2'($urandom);
        end while (!rsp_valid && n < 40);
        check("latency", 32'(n - 1), 32'(Settle2));
        check("rsp_y", 32'(rsp_y), 32'(ey));
        check("rsp_flags", 32'(rsp_flags), 32'(eflags));
        check("rsp_err", 32'(rsp_err), 32'(eerr));
        check("err_cnt", 32'(err_cnt), 32'(ref_cnt));
        check("cmd_ready_resp", 32'(cmd_ready), 32'd0);
        check("alu_ab_held", {16'd0, alu_a, alu_b}, {16'd0, a, b});
        check("alu_op_held", 32'(alu_op), 32'(op));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'($urandom);
            y_noise   = 8'($urandom);
            flag_mode = 2'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_y", 32'(rsp_y), 32'(ey));
            check("bp_rsp_flags", 32'(rsp_flags), 32'(eflags));
            check("bp_rsp_err", 32'(rsp_err), 32'(eerr));
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_alu_ab", {16'd0, alu_a, alu_b}, {16'd0, a, b});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        y_noise   = 8'h00;
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("retain_rsp_y", 32'(rsp_y), 32'(ey));
        check("retain_rsp_err", 32'(rsp_err), 32'(eerr));
    endtask

    task automatic do_cmd4(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int n;
        cmd_valid4 = 1'b1;
        cmd_a      = a;
        cmd_b      = b;
        cmd_op     = op;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            cmd_valid4 = 1'b0;
        end while (!rsp_valid4 && n < 40);
        check("latency4", 32'(n - 1), 32'(Settle4));
        check("rsp_y4", 32'(rsp_y4), 32'(calc(a, b, op)));
        check("rsp_err4", 32'(rsp_err4), 32'd0);
        rsp_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready4 = 1'b0;
        check("idle4", 32'(cmd_ready4), 32'd1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [1:0] mode;
        int         hold;
        logic [7:0] y;
        logic       err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] ra, rb;
        logic [1:0] rop, rmode;
        logic       rerr;
        logic       seen;
        int         n;

        vecs[0] = '{a: 8'h05, b: 8'h03, op: 2'd0, mode: 2'd0, hold: 5, y: 8'h08, err: 1'b0};
        vecs[1] = '{a: 8'h10, b: 8'h10, op: 2'd0, mode: 2'd1, hold: 0, y: 8'h20, err: 1'b1};
        vecs[2] = '{a: 8'h10, b: 8'h10, op: 2'd0, mode: 2'd2, hold: 1, y: 8'h20, err: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'h01, op: 2'd0, mode: 2'd0, hold: 0, y: 8'h00, err: 1'b0};
        vecs[4] = '{a: 8'h03, b: 8'h05, op: 2'd1, mode: 2'd0, hold: 2, y: 8'hFE, err: 1'b0};
        vecs[5] = '{a: 8'hF0, b: 8'h3C, op: 2'd2, mode: 2'd0, hold: 0, y: 8'h30, err: 1'b0};
        vecs[6] = '{a: 8'hF0, b: 8'h3C, op: 2'd3, mode: 2'd1, hold: 0, y: 8'hCC, err: 1'b0};
        vecs[7] = '{a: 8'h07, b: 8'h09, op: 2'd1, mode: 2'd3, hold: 3, y: 8'hFE, err: 1'b1};

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_valid4 = 1'b0;
        rsp_ready  = 1'b0;
        rsp_ready4 = 1'b0;
        cmd_a      = 8'h00;
        cmd_b      = 8'h00;
        cmd_op     = 2'd0;
        flag_mode  = 2'd0;
        y_noise    = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", {14'd0, alu_a, alu_b, alu_op}, 32'd0);
        check("rst_rsp", {18'd0, rsp_y, rsp_flags, rsp_err}, 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].mode, vecs[i].hold,
                   vecs[i].y, vecs[i].err);
        end

        for (int i = 0; i < 40; i++) begin
            ra    = 8'($urandom);
            rb    = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            rop   = 2'($urandom);
            rmode = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
            rerr  = (cmp_pat(ra, rb, rmode) != {ra > rb, ra == rb, ra < rb});
            do_cmd(ra, rb, rop, rmode, $urandom_range(0, 3), calc(ra, rb, rop), rerr);
        end

        for (int i = 0; i < 260; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 2'($urandom);
            do_cmd(ra, rb, rop, 2'd2, 0, calc(ra, rb, rop), 1'b1);
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Park the SETTLE=2 instance in RESP, then reset one cycle into a SETTLE=4 command.
        @(negedge clk);
        flag_mode = 2'd0;
        cmd_valid = 1'b1;
        cmd_a     = 8'h5A;
        cmd_b     = 8'h11;
        cmd_op    = 2'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("resp_before_reset", 32'(rsp_valid), 32'd1);
        cmd_valid4 = 1'b1;
        cmd_a      = 8'h77;
        cmd_b      = 8'h22;
        @(posedge clk);
        @(negedge clk);
        cmd_valid4 = 1'b0;
        check("drive4_alu_a", 32'(alu_a4), 32'h77);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_alu", {14'd0, alu_a, alu_b, alu_op}, 32'd0);
        check("mid_rst_rsp", {18'd0, rsp_y, rsp_flags, rsp_err}, 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst4_alu_a", 32'(alu_a4), 32'd0);
        check("mid_rst4_cmd_ready", 32'(cmd_ready4), 32'd1);
        check("mid_rst4_rsp_valid", 32'(rsp_valid4), 32'd0);
        ref_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid | rsp_valid4;
        end
        check("no_rsp_after_reset", 32'(seen), 32'd0);

        do_cmd4(8'h40, 8'h02, 2'd1);
        do_cmd(8'h21, 8'h21, 2'd3, 2'd0, 0, 8'h00, 1'b0);
        do_cmd(8'h01, 8'h80, 2'd0, 2'd3, 0, 8'h81, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
